// File: rtl/cmp4_sweep_tester.sv
// -----------------------------------------------------------------------------
// cmp4_sweep_tester
//
// Exhaustive stimulus-and-check initiator for a 4-bit magnitude comparator.
// It walks all 256 operand pairs (A = idx[7:4], B = idx[3:0], idx ascending).
// For each pair it waits SETTLE_CYCLES cycles, then samples {AiB,AsB,AeB} and
// compares it against the arithmetic relation of A and B.
//
// Parameters
//   SETTLE_CYCLES : cycles between an operand update and the result sample.
//                   Legal range is 1..15. Each vector takes SETTLE_CYCLES+1
//                   cycles, so a full sweep takes 256*(SETTLE_CYCLES+1).
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   one-cycle sweep request, honoured in IDLE or DONE only
//   A3..A0         out  operand A to the comparator (registered)
//   B3..B0         out  operand B to the comparator (registered)
//   AiB/AsB/AeB    in   comparator results A>B / A<B / A==B
//   busy           out  sweep in progress
//   done           out  sweep finished; held until next accepted start or rst
//   pass           out  done with zero failing vectors
//   err_count      out  number of failing vectors, 0..256
//   first_err_a    out  A of the first failing vector
//   first_err_b    out  B of the first failing vector
//   first_err_obs  out  {AiB,AsB,AeB} observed on the first failing vector
//
// Build option
//   CMP4_SWEEP_FIRST_ERR_EN : when defined, the first-failing-vector capture
//   registers are built. When undefined, first_err_* are tied to zero. The
//   error count, pass flag and all timing are the same in both builds.
// -----------------------------------------------------------------------------
module cmp4_sweep_tester #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A3,
  output logic       A2,
  output logic       A1,
  output logic       A0,
  output logic       B3,
  output logic       B2,
  output logic       B1,
  output logic       B0,
  input  logic       AiB,
  input  logic       AsB,
  input  logic       AeB,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [3:0] first_err_a,
  output logic [3:0] first_err_b,
  output logic [2:0] first_err_obs
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Last value of the settle counter before moving to CHECK.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] err_q, err_d;

  logic [3:0] opa;
  logic [3:0] opb;
  logic [2:0] obs;
  logic [2:0] exp_triple;
  logic       start_ok;
  logic       mismatch;

  // The operand outputs come straight from the index register, so they only
  // change on the edge that accepts start or leaves CHECK.
  assign opa = idx_q[7:4];
  assign opb = idx_q[3:0];
  assign {A3, A2, A1, A0} = opa;
  assign {B3, B2, B1, B0} = opb;

  // The comparator outputs are combinational from our registered operands,
  // so they are sampled directly; the settle window covers their delay.
  assign obs = {AiB, AsB, AeB};

  always_comb begin
    exp_triple = 3'b001;
    if (opa > opb) begin
      exp_triple = 3'b100;
    end else if (opa < opb) begin
      exp_triple = 3'b010;
    end
  end

  // Whole-triple compare: non-one-hot and all-zero results count as errors.
  assign mismatch = (state_q == ST_CHECK) && (obs != exp_triple);

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          idx_d   = 8'd0;
          cnt_d   = 4'd0;
          err_d   = 9'd0;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // At most 256 increments per sweep, so 9 bits never wrap.
        if (mismatch) begin
          err_d = err_q + 9'd1;
        end
        if (idx_q == 8'hFF) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          cnt_d   = 4'd0;
          state_d = ST_SETTLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      cnt_q   <= 4'd0;
      err_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == 9'd0);
  assign err_count = err_q;

`ifdef CMP4_SWEEP_FIRST_ERR_EN
  logic       first_seen_q;
  logic [3:0] first_a_q;
  logic [3:0] first_b_q;
  logic [2:0] first_obs_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      first_seen_q <= 1'b0;
      first_a_q    <= 4'd0;
      first_b_q    <= 4'd0;
      first_obs_q  <= 3'd0;
    end else if (mismatch && !first_seen_q) begin
      first_seen_q <= 1'b1;
      first_a_q    <= opa;
      first_b_q    <= opb;
      first_obs_q  <= obs;
    end
  end

  assign first_err_a   = first_a_q;
  assign first_err_b   = first_b_q;
  assign first_err_obs = first_obs_q;
`else
  assign first_err_a   = 4'd0;
  assign first_err_b   = 4'd0;
  assign first_err_obs = 3'd0;
`endif

endmodule

// File: tb/tb_cmp4_sweep_tester.sv
// -----------------------------------------------------------------------------
// Bench for cmp4_sweep_tester. Four testers run side by side on one clock and
// share rst/start:
//   u0: SETTLE_CYCLES=4, zero-delay comparator with injectable faults
//   u1: SETTLE_CYCLES=1, ideal zero-delay comparator
//   u2: SETTLE_CYCLES=2, ideal comparator with 3-cycle output delay
//   u3: SETTLE_CYCLES=4, ideal comparator with 3-cycle output delay
// Expected results come from enumerating all 256 pairs with the comparator's
// behaviour (fault and delay) applied to the pair that is actually visible at
// the sample point.
// -----------------------------------------------------------------------------
module tb_cmp4_sweep_tester;

  localparam int N_DUT = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Fault controls for u0's comparator model.
  int         fault_mode;
  int         fault_bit;
  logic       fault_val;
  int         fault_idx;
  logic [2:0] fault_xor;

  int prev_idx[N_DUT];

  logic [N_DUT-1:0][3:0] a_w;
  logic [N_DUT-1:0][3:0] b_w;
  logic [N_DUT-1:0]      busy_w;
  logic [N_DUT-1:0]      done_w;
  logic [N_DUT-1:0]      pass_w;
  logic [N_DUT-1:0][8:0] errc_w;
  logic [N_DUT-1:0][3:0] fea_w;
  logic [N_DUT-1:0][3:0] feb_w;
  logic [N_DUT-1:0][2:0] feo_w;

  function automatic int settle_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int delay_of(input int i);
    return (i >= 2) ? 3 : 0;
  endfunction

  function automatic logic [2:0] ideal_rel(input int a, input int b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  // Comparator behaviour: 0 ideal, 1 AeB stuck at 0, 2 AiB/AsB swapped,
  // 3 one output stuck, 4 corrupted result on one operand pair.
  function automatic logic [2:0] cmp_obs(input int a, input int b, input int mode);
    logic [2:0] t;
    t = ideal_rel(a, b);
    case (mode)
      1: t[0] = 1'b0;
      2: t = {t[1], t[2], t[0]};
      3: t[fault_bit] = fault_val;
      4: if (a * 16 + b == fault_idx) t = t ^ fault_xor;
      default: ;
    endcase
    return t;
  endfunction

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    localparam int S = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : 4;
    localparam int D = (gi >= 2) ? 3 : 0;

    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] raw;
    logic [2:0] obs;

    always_comb raw = cmp_obs(int'(a), int'(b), (gi == 0) ? fault_mode : 0);

    if (D == 0) begin : g_nodly
      assign obs = raw;
    end else begin : g_dly
      logic [2:0] p1, p2, p3;
      always @(posedge clk) begin
        p1 <= raw;
        p2 <= p1;
        p3 <= p2;
      end
      assign obs = p3;
    end

    assign a_w[gi] = a;
    assign b_w[gi] = b;

    cmp4_sweep_tester #(.SETTLE_CYCLES(S)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .A3            (a[3]),
      .A2            (a[2]),
      .A1            (a[1]),
      .A0            (a[0]),
      .B3            (b[3]),
      .B2            (b[2]),
      .B1            (b[1]),
      .B0            (b[0]),
      .AiB           (obs[2]),
      .AsB           (obs[1]),
      .AeB           (obs[0]),
      .busy          (busy_w[gi]),
      .done          (done_w[gi]),
      .pass          (pass_w[gi]),
      .err_count     (errc_w[gi]),
      .first_err_a   (fea_w[gi]),
      .first_err_b   (feb_w[gi]),
      .first_err_obs (feo_w[gi])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check_reset(input int i);
    check_val($sformatf("u%0d_rst_busy", i), busy_w[i], 0);
    check_val($sformatf("u%0d_rst_done", i), done_w[i], 0);
    check_val($sformatf("u%0d_rst_pass", i), pass_w[i], 0);
    check_val($sformatf("u%0d_rst_err", i), errc_w[i], 0);
    check_val($sformatf("u%0d_rst_a", i), a_w[i], 0);
    check_val($sformatf("u%0d_rst_b", i), b_w[i], 0);
    check_val($sformatf("u%0d_rst_fea", i), fea_w[i], 0);
    check_val($sformatf("u%0d_rst_feb", i), feb_w[i], 0);
    check_val($sformatf("u%0d_rst_feo", i), feo_w[i], 0);
  endtask

  // Reference: the sample taken in CHECK of vector k sees the comparator's
  // answer for the operands present D cycles earlier. That is vector k when
  // S >= D, otherwise the previous vector (or the pre-start operands for k=0).
  task automatic model_sweep(input int s, input int d, input int mode, input int prev,
                             output int errs, output logic [3:0] fa,
                             output logic [3:0] fb, output logic [2:0] fo);
    bit seen;
    seen = 0;
    errs = 0;
    fa = 0;
    fb = 0;
    fo = 0;
    for (int k = 0; k < 256; k++) begin
      int src;
      logic [2:0] got;
      src = (s >= d) ? k : ((k == 0) ? prev : k - 1);
      got = cmp_obs(src / 16, src % 16, mode);
      if (got != ideal_rel(k / 16, k % 16)) begin
        errs++;
        if (!seen) begin
          seen = 1;
          fa = 4'(k / 16);
          fb = 4'(k % 16);
          fo = got;
        end
      end
    end
`ifndef CMP4_SWEEP_FIRST_ERR_EN
    fa = 0;
    fb = 0;
    fo = 0;
`endif
  endtask

  task automatic run_sweep(input string name, input int mode);
    int         exp_err[N_DUT];
    logic [3:0] exp_fa[N_DUT];
    logic [3:0] exp_fb[N_DUT];
    logic [2:0] exp_fo[N_DUT];
    int         done_at[N_DUT];
    int         edges;
    bit         all_done;

    fault_mode = mode;
    for (int i = 0; i < N_DUT; i++) begin
      model_sweep(settle_of(i), delay_of(i), (i == 0) ? mode : 0, prev_idx[i],
                  exp_err[i], exp_fa[i], exp_fb[i], exp_fo[i]);
      done_at[i] = -1;
    end

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      check_val($sformatf("%s_u%0d_busy_after_start", name, i), busy_w[i], 1);
      check_val($sformatf("%s_u%0d_ops_after_start", name, i), {a_w[i], b_w[i]}, 0);
    end

    // Stray start pulses land only while every tester is still busy.
    edges = 0;
    while (edges < 2000) begin
      all_done = 1;
      for (int i = 0; i < N_DUT; i++) if (done_at[i] < 0) all_done = 0;
      if (all_done) break;
      start = (edges > 3 && edges < 400 && $urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
      edges++;
      for (int i = 0; i < N_DUT; i++) begin
        if (done_at[i] < 0 && done_w[i] === 1'b1) begin
          done_at[i] = edges;
          check_val($sformatf("%s_u%0d_busy_at_done", name, i), busy_w[i], 0);
        end
      end
    end
    start = 1'b0;

    for (int i = 0; i < N_DUT; i++) begin
      check_val($sformatf("%s_u%0d_done_cycle", name, i), done_at[i], 256 * (settle_of(i) + 1));
      check_val($sformatf("%s_u%0d_err_count", name, i), errc_w[i], exp_err[i]);
      check_val($sformatf("%s_u%0d_pass", name, i), pass_w[i], (exp_err[i] == 0));
      check_val($sformatf("%s_u%0d_first_a", name, i), fea_w[i], exp_fa[i]);
      check_val($sformatf("%s_u%0d_first_b", name, i), feb_w[i], exp_fb[i]);
      check_val($sformatf("%s_u%0d_first_obs", name, i), feo_w[i], exp_fo[i]);
      check_val($sformatf("%s_u%0d_ops_hold", name, i), {a_w[i], b_w[i]}, 8'hFF);
      prev_idx[i] = 255;
    end
    $display("sweep %s mode=%0d: u0 err=%0d u1 err=%0d u2 err=%0d u3 err=%0d",
             name, mode, errc_w[0], errc_w[1], errc_w[2], errc_w[3]);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    fault_mode = 0;
    fault_bit  = 0;
    fault_val  = 1'b0;
    fault_idx  = 0;
    fault_xor  = 3'b001;
    for (int i = 0; i < N_DUT; i++) prev_idx[i] = 0;

    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) check_reset(i);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    run_sweep("ideal", 0);

    run_sweep("aeb_stuck0", 1);
    check_val("aeb_stuck0_known_count", errc_w[0], 16);

    run_sweep("swap_gt_lt", 2);
    check_val("swap_known_count", errc_w[0], 240);

    for (int r = 0; r < 4; r++) begin
      fault_bit = $urandom_range(0, 2);
      fault_val = 1'($urandom_range(0, 1));
      fault_idx = $urandom_range(0, 255);
      fault_xor = 3'($urandom_range(1, 7));
      run_sweep($sformatf("random%0d", r), $urandom_range(0, 4));
    end

    // Reset in the middle of a sweep, coincident with a start pulse.
    fault_mode = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 499; c++) begin
      start = (c > 3 && $urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
    end
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      check_reset(i);
      prev_idx[i] = 0;
    end
    $display("mid-sweep reset applied");
    repeat (4) @(posedge clk);
    #1;
    run_sweep("after_reset", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
